// File: rtl/ppt_fire_sequencer.sv
// ppt_fire_sequencer: turns each rising edge of the trigger pulse into a safe
// discharge sequence (charge stop, dead time, fire gate, recharge). It also
// watches for charge timeouts and counts triggers that arrive while busy.
// No valid/ready handshakes here: every input is a level or single-cycle
// strobe sampled on each clock edge.
module ppt_fire_sequencer #(
  parameter int unsigned DEAD_CYC  = 4,
  parameter int unsigned FIRE_CYC  = 8,
  parameter int unsigned CHARGE_TO = 1000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        arm,
  input  logic        pulse_in,
  input  logic        cap_ready,
  input  logic        clear_fault,
  input  logic        clr_counts,
  output logic        charge_en,
  output logic        fire_out,
  output logic        ready,
  output logic        fault,
  output logic [15:0] fire_count,
  output logic [7:0]  miss_count
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHARGE,
    S_READY,
    S_DEAD,
    S_FIRE,
    S_FAULT
  } state_t;

  // Last phase-counter value of each timed state.
  localparam logic [15:0] DEAD_LAST   = 16'(DEAD_CYC - 1);
  localparam logic [15:0] FIRE_LAST   = 16'(FIRE_CYC - 1);
  localparam logic [15:0] CHARGE_LAST = 16'(CHARGE_TO - 1);

  state_t      state;
  state_t      state_nxt;
  logic        ps1, ps2, ps3;
  logic        cr1, crdy;
  logic        trig;
  logic [15:0] phase;
  logic        fire_step;
  logic        miss_step;
  logic        busy;

  // Two-flop synchronisers; ps3 is the extra stage for edge detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      ps1  <= 1'b0;
      ps2  <= 1'b0;
      ps3  <= 1'b0;
      cr1  <= 1'b0;
      crdy <= 1'b0;
    end else begin
      ps1  <= pulse_in;
      ps2  <= ps1;
      ps3  <= ps2;
      cr1  <= cap_ready;
      crdy <= cr1;
    end
  end

  assign trig = ps2 & ~ps3;

  // Next-state selection; FAULT is sticky until clear_fault, disarm wins elsewhere.
  always_comb begin
    state_nxt = state;
    if (state == S_FAULT) begin
      if (clear_fault) state_nxt = S_IDLE;
    end else if (!arm) begin
      state_nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE:   state_nxt = S_CHARGE;
        S_CHARGE: begin
          if (crdy)                      state_nxt = S_READY;
          else if (phase == CHARGE_LAST) state_nxt = S_FAULT;
        end
        S_READY:  if (trig) state_nxt = S_DEAD;
        S_DEAD:   if (phase == DEAD_LAST) state_nxt = S_FIRE;
        S_FIRE:   if (phase == FIRE_LAST) state_nxt = S_CHARGE;
        default:  state_nxt = state;
      endcase
    end
  end

  // A trigger is a miss only when armed and in a state that cannot accept it.
  assign busy      = (state == S_CHARGE) || (state == S_DEAD) || (state == S_FIRE);
  assign miss_step = trig && arm && busy;
  assign fire_step = (state == S_DEAD) && (state_nxt == S_FIRE);

  // State, phase counter, registered Moore outputs and saturating counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      phase      <= 16'd0;
      charge_en  <= 1'b0;
      fire_out   <= 1'b0;
      ready      <= 1'b0;
      fault      <= 1'b0;
      fire_count <= 16'd0;
      miss_count <= 8'd0;
    end else begin
      state     <= state_nxt;
      phase     <= (state_nxt != state) ? 16'd0 : phase + 16'd1;
      charge_en <= (state_nxt == S_CHARGE) || (state_nxt == S_READY);
      fire_out  <= (state_nxt == S_FIRE);
      ready     <= (state_nxt == S_READY);
      fault     <= (state_nxt == S_FAULT);
      if (clr_counts) begin
        fire_count <= 16'd0;
        miss_count <= 8'd0;
      end else begin
        if (fire_step && (fire_count != 16'hFFFF)) fire_count <= fire_count + 16'd1;
        if (miss_step && (miss_count != 8'hFF))    miss_count <= miss_count + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_ppt_fire_sequencer.sv
// Bench for ppt_fire_sequencer: directed steps plus randomised fire sequences
// checked against a timeline model derived from the trigger latency rules.
module tb_ppt_fire_sequencer;

  localparam int D   = 4;
  localparam int F   = 8;
  localparam int CTO = 20;
  // One sequence: trigger sample edge 0, back in READY at edge 3+D+F, plus slack.
  localparam int SEQ_LEN   = 3 + D + F + 2;
  localparam int LAST_MISS = 1 + D + F;

  logic        clk = 1'b0;
  logic        rst, arm, pulse_in, cap_ready, clear_fault, clr_counts;
  logic        charge_en, fire_out, ready, fault;
  logic [15:0] fire_count;
  logic [7:0]  miss_count;

  int          n_checks = 0;
  int          n_pass   = 0;
  int          exp_fire = 0;
  int          exp_miss = 0;
  logic [3:0]  exp_q[$];
  logic [31:0] pat;

  ppt_fire_sequencer #(.DEAD_CYC(D), .FIRE_CYC(F), .CHARGE_TO(CTO)) dut (
    .clk(clk), .rst(rst), .arm(arm), .pulse_in(pulse_in), .cap_ready(cap_ready),
    .clear_fault(clear_fault), .clr_counts(clr_counts), .charge_en(charge_en),
    .fire_out(fire_out), .ready(ready), .fault(fault), .fire_count(fire_count),
    .miss_count(miss_count)
  );

  // Clock
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic int sat(input int v, input int m);
    return (v > m) ? m : v;
  endfunction

  // Main trigger of width w at edge 0, then optional random extra pulses that
  // land while the sequence is busy (each preceded by at least two low samples).
  function automatic logic [31:0] make_pattern(input int w, input bit with_misses);
    logic [31:0] p;
    int          n;
    int          hw;
    p = '0;
    for (int i = 0; i < w; i++) p[i] = 1'b1;
    if (with_misses) begin
      n = w + 2;
      while (n <= LAST_MISS) begin
        if ($urandom_range(0, 1) == 1) begin
          hw = $urandom_range(1, 2);
          for (int j = 0; j < hw; j++) p[n + j] = 1'b1;
          n = n + hw + 2;
        end else begin
          n = n + 1;
        end
      end
    end
    return p;
  endfunction

  // Model + driver for one sequence starting in READY with pulse_in low.
  task automatic run_seq(input logic [31:0] p, input bit clr_at_fire);
    int rises;
    bit fire_w, busy_w, rdy_w;
    rises = 0;
    for (int n = 0; n < SEQ_LEN; n++) begin
      busy_w = (n >= 2) && (n < 2 + D + F);
      fire_w = (n >= 2 + D) && (n < 2 + D + F);
      rdy_w  = (n < 2) || (n >= 3 + D + F);
      exp_q.push_back({~busy_w, fire_w, rdy_w, 1'b0});
    end
    for (int n = 1; n < SEQ_LEN; n++) if (p[n] && !p[n - 1]) rises++;
    if (clr_at_fire) begin
      exp_fire = 0;
      exp_miss = 0;
    end else begin
      exp_fire = sat(exp_fire + 1, 65535);
      exp_miss = sat(exp_miss + rises, 255);
    end
    for (int n = 0; n < SEQ_LEN; n++) begin
      pulse_in   = p[n];
      clr_counts = clr_at_fire && (n == 2 + D);
      tick();
      check_eq($sformatf("wave n=%0d", n), {charge_en, fire_out, ready, fault}, exp_q.pop_front());
    end
    pulse_in   = 1'b0;
    clr_counts = 1'b0;
    check_eq("seq_fire_count", fire_count, exp_fire);
    check_eq("seq_miss_count", miss_count, exp_miss);
  endtask

  task automatic to_ready;
    arm       = 1'b1;
    cap_ready = 1'b1;
    pulse_in  = 1'b0;
    repeat (4) tick();
    check_eq("to_ready", ready, 1);
  endtask

  initial begin
    // Reset with arm and cap_ready already high: outputs must stay 0.
    rst = 1'b1; arm = 1'b1; cap_ready = 1'b1; pulse_in = 1'b0;
    clear_fault = 1'b0; clr_counts = 1'b0;
    tick();
    tick();
    check_eq("rst_outs", {charge_en, fire_out, ready, fault}, 4'b0000);
    check_eq("rst_fire_count", fire_count, 0);
    check_eq("rst_miss_count", miss_count, 0);

    // Arm: CHARGE one edge after release, READY on the third edge.
    rst = 1'b0;
    tick();
    check_eq("arm_charge", {charge_en, fire_out, ready, fault}, 4'b1000);
    tick();
    check_eq("arm_not_ready", ready, 0);
    tick();
    check_eq("arm_ready", {charge_en, fire_out, ready, fault}, 4'b1010);

    // Normal fire with a 3-cycle pulse, then a fire with a miss during FIRE.
    run_seq(32'h7, 1'b0);
    run_seq(32'h107, 1'b0);

    // Disarm, flush crdy low, then re-arm into a charge timeout with a miss in CHARGE.
    arm = 1'b0; cap_ready = 1'b0;
    tick();
    check_eq("disarm_idle", {charge_en, ready}, 2'b00);
    tick();
    tick();
    arm = 1'b1;
    tick();
    check_eq("to_charge", {charge_en, fault}, 2'b10);
    for (int i = 1; i < CTO; i++) begin
      pulse_in = (i == 2) || (i == 3);
      tick();
      check_eq($sformatf("charge_hold i=%0d", i), {charge_en, fault}, 2'b10);
    end
    pulse_in = 1'b0;
    exp_miss = sat(exp_miss + 1, 255);
    tick();
    check_eq("timeout_fault", {charge_en, fire_out, ready, fault}, 4'b0001);
    check_eq("miss_two", miss_count, exp_miss);
    check_eq("fire_two", fire_count, exp_fire);

    // FAULT survives disarm and ignores triggers.
    arm = 1'b0;
    repeat (3) tick();
    check_eq("fault_sticky", fault, 1);
    arm = 1'b1; pulse_in = 1'b1;
    tick();
    tick();
    pulse_in = 1'b0;
    repeat (3) tick();
    check_eq("fault_trig_ignored", miss_count, exp_miss);
    check_eq("fault_still", fault, 1);
    arm = 1'b0; clear_fault = 1'b1;
    tick();
    check_eq("clear_fault", {charge_en, fire_out, ready, fault}, 4'b0000);
    clear_fault = 1'b0;
    pulse_in = 1'b1;
    tick();
    pulse_in = 1'b0;
    repeat (3) tick();
    check_eq("idle_trig_ignored", miss_count, exp_miss);

    // Disarm on the third FIRE cycle: gate drops at the next edge.
    to_ready();
    pulse_in = 1'b1;
    tick();
    pulse_in = 1'b0;
    repeat (8) tick();
    check_eq("fire_3rd_cycle", {charge_en, fire_out}, 2'b01);
    arm = 1'b0;
    tick();
    exp_fire = sat(exp_fire + 1, 65535);
    check_eq("disarm_fire", {charge_en, fire_out, ready, fault}, 4'b0000);
    check_eq("disarm_fire_count", fire_count, exp_fire);

    // Random sequences with random trigger widths and busy-time misses.
    to_ready();
    for (int s = 0; s < 20; s++) begin
      pat = make_pattern($urandom_range(1, 4), 1'b1);
      run_seq(pat, 1'b0);
    end

    // Four misses per sequence drive miss_count past saturation.
    for (int s = 0; s < 65; s++) run_seq(32'h1249, 1'b0);
    check_eq("miss_saturated", miss_count, 8'hFF);

    // clr_counts on the DEAD->FIRE edge wins over the fire increment.
    run_seq(32'h1, 1'b1);
    check_eq("clr_fire_zero", fire_count, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
